// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter:
// access size codes, FSM states and the byte-lane mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_ILL  = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic [3:0] m;
        m = 4'b0000;
        unique case (size)
            SZ_BYTE: m = 4'b0001 << offset;
            SZ_HALF: m = 4'b0011 << offset;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Request/response and memory-side bundle of the data memory arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]             req_valid_i;
    logic [1:0]             req_ready_o;
    logic [1:0]             req_we_i;
    logic [1:0][1:0]        req_size_i;
    logic [1:0][ADDR_W-1:0] req_addr_i;
    logic [1:0][DATA_W-1:0] req_wdata_i;
    logic [1:0]             resp_valid_o;
    logic                   resp_err_o;
    logic [DATA_W-1:0]      resp_rdata_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_wr_data_o;
    logic [3:0]             mem_wr_enable_o;
    logic [1:0]             mem_rd_enable_o;
    logic [DATA_W-1:0]      mem_rd_data_i;

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_size_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  mem_rd_data_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_err_o,
        output resp_rdata_o,
        output mem_addr_o,
        output mem_wr_data_o,
        output mem_wr_enable_o,
        output mem_rd_enable_o
    );

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_size_i,
        output req_addr_i,
        output req_wdata_i,
        output mem_rd_data_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_err_o,
        input  resp_rdata_o,
        input  mem_addr_o,
        input  mem_wr_data_o,
        input  mem_wr_enable_o,
        input  mem_rd_enable_o
    );

endinterface

// File: rtl/data_memory_arbiter_lane_align.sv
// Alignment check, byte-lane mask and store-data shift
// for a single request (purely combinational).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic              misaligned,
    output logic [3:0]        mask,
    output logic [DATA_W-1:0] wdata_sh
);

    always_comb begin
        misaligned = 1'b1;
        unique case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = offset[0];
            SZ_WORD: misaligned = |offset;
            default: misaligned = 1'b1;
        endcase
    end

    assign mask     = byte_mask(size, offset);
    assign wdata_sh = wdata << {offset, 3'b000};

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory;
// rejects misaligned accesses without touching the memory.
module data_memory_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input logic                 clock_i,
    input logic                 reset_i,
    data_memory_arbiter_if.slave bus
);

    state_e state;
    state_e state_nx;

    logic              rr_last;
    logic              req_any;
    logic              grant;
    logic [1:0]        cnt;
    logic              sel_err;
    logic [3:0]        sel_mask;
    logic [DATA_W-1:0] sel_wdata;

    logic              lt_port;
    logic              lt_we;
    logic              lt_err;
    logic [1:0]        lt_size;
    logic [3:0]        lt_mask;
    logic [DATA_W-1:0] lt_wdata;
    logic [ADDR_W-1:0] lt_addr;

    // Lone requester wins; on contention the port that lost last time wins.
    assign req_any = |bus.req_valid_i;
    assign grant   = (&bus.req_valid_i) ? ~rr_last : bus.req_valid_i[1];

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size       (bus.req_size_i[grant]),
        .offset     (bus.req_addr_i[grant][1:0]),
        .wdata      (bus.req_wdata_i[grant]),
        .misaligned (sel_err),
        .mask       (sel_mask),
        .wdata_sh   (sel_wdata)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_any) state_nx = sel_err ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                if (lt_we || RD_LATENCY <= 1) state_nx = S_RESP;
                else                          state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 2'(RD_LATENCY - 2)) state_nx = S_RESP;
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_last  <= 1'b1;
            cnt      <= 2'd0;
            lt_port  <= 1'b0;
            lt_we    <= 1'b0;
            lt_err   <= 1'b0;
            lt_size  <= 2'b00;
            lt_mask  <= 4'b0000;
            lt_wdata <= '0;
            lt_addr  <= '0;
        end else begin
            if (state == S_IDLE && req_any) begin
                rr_last  <= grant;
                lt_port  <= grant;
                lt_we    <= bus.req_we_i[grant];
                lt_err   <= sel_err;
                lt_size  <= bus.req_size_i[grant];
                lt_mask  <= sel_mask;
                lt_wdata <= sel_wdata;
                lt_addr  <= {bus.req_addr_i[grant][ADDR_W-1:2], 2'b00};
            end
            if (state == S_WAIT) cnt <= cnt + 2'd1;
            else                 cnt <= 2'd0;
        end
    end

    // Ready is masked by reset so every output is quiet while it is held.
    always_comb begin
        bus.req_ready_o     = 2'b00;
        bus.mem_wr_enable_o = 4'b0000;
        bus.mem_wr_data_o   = '0;
        bus.mem_rd_enable_o = 2'b00;
        bus.resp_valid_o    = 2'b00;
        bus.resp_err_o      = 1'b0;
        bus.resp_rdata_o    = '0;
        unique case (state)
            S_IDLE: begin
                if (req_any && !reset_i) bus.req_ready_o = 2'b01 << grant;
            end
            S_ISSUE: begin
                if (lt_we) begin
                    bus.mem_wr_enable_o = lt_mask;
                    bus.mem_wr_data_o   = lt_wdata;
                end else begin
                    bus.mem_rd_enable_o = lt_size;
                end
            end
            S_RESP: begin
                bus.resp_valid_o = 2'b01 << lt_port;
                bus.resp_err_o   = lt_err;
                if (!lt_we && !lt_err) bus.resp_rdata_o = bus.mem_rd_data_i;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o = lt_addr;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: vector table on a
// RD_LATENCY=1 instance plus contention and reset-in-WAIT sequences.
module tb_data_memory_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    data_memory_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)
    ) dut1 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (b1)
    );

    data_memory_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)
    ) dut3 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (b3)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        err;
        logic [3:0]  wen;
        logic [31:0] wdat;
        logic [1:0]  ren;
        logic [31:0] maddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        b1.req_valid_i   = 2'b00;
        b1.req_we_i      = 2'b00;
        b1.req_size_i    = '0;
        b1.req_addr_i    = '0;
        b1.req_wdata_i   = '0;
        b1.mem_rd_data_i = '0;
        b3.req_valid_i   = 2'b00;
        b3.req_we_i      = 2'b00;
        b3.req_size_i    = '0;
        b3.req_addr_i    = '0;
        b3.req_wdata_i   = '0;
        b3.mem_rd_data_i = '0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [1:0] oh;
        oh = 2'b01 << v.port;
        @(negedge clk);
        b1.req_valid_i          = oh;
        b1.req_we_i[v.port]     = v.we;
        b1.req_size_i[v.port]   = v.size;
        b1.req_addr_i[v.port]   = v.addr;
        b1.req_wdata_i[v.port]  = v.wdata;
        b1.mem_rd_data_i        = v.mdata;
        #1;
        check($sformatf("v%0d ready", i), 32'(b1.req_ready_o), 32'(oh));
        check($sformatf("v%0d idle en", i),
              32'({b1.mem_wr_enable_o, b1.mem_rd_enable_o}), 32'h0);
        @(posedge clk);
        #1;
        // Drop the request and scramble inputs: only latched values count.
        b1.req_valid_i = 2'b00;
        b1.req_we_i    = ~b1.req_we_i;
        b1.req_size_i  = '0;
        b1.req_addr_i  = '1;
        b1.req_wdata_i = {2{32'h5555_5555}};
        if (!v.err) begin
            check($sformatf("v%0d wen", i), 32'(b1.mem_wr_enable_o), 32'(v.wen));
            check($sformatf("v%0d wdata", i), b1.mem_wr_data_o, v.wdat);
            check($sformatf("v%0d ren", i), 32'(b1.mem_rd_enable_o), 32'(v.ren));
            check($sformatf("v%0d addr", i), b1.mem_addr_o, v.maddr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d addr hold", i), b1.mem_addr_o, v.maddr);
        end
        check($sformatf("v%0d resp", i), 32'(b1.resp_valid_o), 32'(oh));
        check($sformatf("v%0d err", i), 32'(b1.resp_err_o), 32'(v.err));
        check($sformatf("v%0d rdata", i), b1.resp_rdata_o, v.rdata);
        check($sformatf("v%0d resp en", i),
              32'({b1.mem_wr_enable_o, b1.mem_rd_enable_o}), 32'h0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d resp end", i), 32'(b1.resp_valid_o), 32'h0);
    endtask

    initial begin
        int gcnt;
        int r0;
        int r1;
        int both;
        int lat;
        int order[4];

        vecs[0] = '{1'b0, 1'b1, SZ_WORD, 32'h1C, 32'hDEADBEEF, 32'h0,
                    1'b0, 4'b1111, 32'hDEADBEEF, 2'b00, 32'h1C, 32'h0};
        vecs[1] = '{1'b1, 1'b1, SZ_BYTE, 32'h0E, 32'h000000A5, 32'h0,
                    1'b0, 4'b0100, 32'h00A50000, 2'b00, 32'h0C, 32'h0};
        vecs[2] = '{1'b0, 1'b0, SZ_HALF, 32'h08, 32'h0, 32'h0000FFFF,
                    1'b0, 4'b0000, 32'h0, 2'b10, 32'h08, 32'h0000FFFF};
        vecs[3] = '{1'b0, 1'b0, SZ_WORD, 32'h06, 32'h0, 32'h12345678,
                    1'b1, 4'b0000, 32'h0, 2'b00, 32'h04, 32'h0};
        vecs[4] = '{1'b0, 1'b0, SZ_ILL, 32'h04, 32'h0, 32'h12345678,
                    1'b1, 4'b0000, 32'h0, 2'b00, 32'h04, 32'h0};
        vecs[5] = '{1'b1, 1'b1, SZ_HALF, 32'h02, 32'h0000BEEF, 32'h0,
                    1'b0, 4'b1100, 32'hBEEF0000, 2'b00, 32'h00, 32'h0};
        vecs[6] = '{1'b1, 1'b0, SZ_BYTE, 32'h13, 32'h0, 32'h11223344,
                    1'b0, 4'b0000, 32'h0, 2'b01, 32'h10, 32'h11223344};
        vecs[7] = '{1'b1, 1'b1, SZ_HALF, 32'h01, 32'h00001234, 32'h0,
                    1'b1, 4'b0000, 32'h0, 2'b00, 32'h00, 32'h0};
        vecs[8] = '{1'b0, 1'b1, SZ_BYTE, 32'h03, 32'h0000007F, 32'h0,
                    1'b0, 4'b1000, 32'h7F000000, 2'b00, 32'h00, 32'h0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        b1.req_valid_i = 2'b01;
        #1;
        check("rst ready", 32'(b1.req_ready_o), 32'h0);
        check("rst resp", 32'({b1.resp_valid_o, b1.resp_err_o}), 32'h0);
        check("rst en", 32'({b1.mem_wr_enable_o, b1.mem_rd_enable_o}), 32'h0);
        check("rst addr", b1.mem_addr_o, 32'h0);
        check("rst wdata", b1.mem_wr_data_o, 32'h0);
        check("rst rdata", b1.resp_rdata_o, 32'h0);
        b1.req_valid_i = 2'b00;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Contention from reset: grants must alternate starting at port 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b1.req_valid_i = 2'b11;
        b1.req_we_i    = 2'b11;
        b1.req_size_i  = {SZ_WORD, SZ_WORD};
        b1.req_addr_i  = {32'h80, 32'h40};
        b1.req_wdata_i = {32'h2222_2222, 32'h1111_1111};
        gcnt = 0;
        r0   = 0;
        r1   = 0;
        both = 0;
        for (int k = 0; k < 4; k++) order[k] = 7;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (b1.req_ready_o != 2'b00) begin
                if (gcnt < 4)
                    order[gcnt] = (b1.req_ready_o == 2'b01) ? 0 :
                                  (b1.req_ready_o == 2'b10) ? 1 : 3;
                gcnt++;
            end
            if (b1.resp_valid_o == 2'b01) r0++;
            if (b1.resp_valid_o == 2'b10) r1++;
            if (b1.resp_valid_o == 2'b11) both++;
            @(negedge clk);
        end
        b1.req_valid_i = 2'b00;
        check("rr grants", 32'(gcnt), 32'd4);
        check("rr g0", 32'(order[0]), 32'd0);
        check("rr g1", 32'(order[1]), 32'd1);
        check("rr g2", 32'(order[2]), 32'd0);
        check("rr g3", 32'(order[3]), 32'd1);
        check("rr resp0", 32'(r0), 32'd2);
        check("rr resp1", 32'(r1), 32'd2);
        check("rr resp both", 32'(both), 32'd0);

        // Reset pulse while the latency-3 instance sits in WAIT.
        @(negedge clk);
        b3.req_valid_i      = 2'b01;
        b3.req_we_i         = 2'b00;
        b3.req_size_i[0]    = SZ_WORD;
        b3.req_addr_i[0]    = 32'h20;
        b3.mem_rd_data_i    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        b3.req_valid_i = 2'b00;
        check("w3 issue ren", 32'(b3.mem_rd_enable_o), 32'h3);
        check("w3 issue addr", b3.mem_addr_o, 32'h20);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("w3 rst en",
              32'({b3.mem_wr_enable_o, b3.mem_rd_enable_o}), 32'h0);
        check("w3 rst resp", 32'({b3.resp_valid_o, b3.resp_err_o}), 32'h0);
        check("w3 rst addr", b3.mem_addr_o, 32'h0);
        check("w3 rst rdata", b3.resp_rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        r0 = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b3.resp_valid_o != 2'b00) r0++;
        end
        check("w3 no resp", 32'(r0), 32'd0);

        // Next request on the same instance is served with full latency.
        b3.req_valid_i = 2'b01;
        #1;
        check("w3 ready", 32'(b3.req_ready_o), 32'h1);
        @(posedge clk);
        #1;
        b3.req_valid_i = 2'b00;
        check("w3b issue ren", 32'(b3.mem_rd_enable_o), 32'h3);
        lat = 1;
        for (int c = 0; c < 8; c++) begin
            if (b3.resp_valid_o != 2'b00) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("w3b latency", 32'(lat), 32'd4);
        check("w3b resp", 32'(b3.resp_valid_o), 32'h1);
        check("w3b err", 32'(b3.resp_err_o), 32'h0);
        check("w3b rdata", b3.resp_rdata_o, 32'hCAFEF00D);
        check("w3b addr", b3.mem_addr_o, 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
